// File: rtl/stage5_twiddle_mult.sv
// Stage-5 twiddle multiplier: W16^k rotation of the stage-4 butterfly stream.
// Three register stages: input/ROM read, products, round+saturate.
module stage5_twiddle_mult #(
   parameter int N            = 256,
   parameter int SIZE         = 8,
   parameter int bit_width    = 16,
   parameter int bit_width_tw = 14
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   input  logic                           in_sop,
   input  logic signed [bit_width-1:0]    in_re,
   input  logic signed [bit_width-1:0]    in_im,
   output logic [SIZE-6:0]                rd_ptr_angle,
   output logic                           en,
   input  logic signed [bit_width_tw-1:0] cos_data,
   input  logic signed [bit_width_tw-1:0] sin_data,
   output logic                           out_valid,
   output logic                           out_sop,
   output logic signed [bit_width-1:0]    out_re,
   output logic signed [bit_width-1:0]    out_im
);

   localparam int PW   = bit_width + bit_width_tw;
   localparam int SW   = PW + 1;
   localparam int FRAC = bit_width_tw - 2;

   localparam logic signed [SW-1:0] C_RND = SW'(2 ** (FRAC - 1));
   localparam logic signed [SW-1:0] C_MAX = SW'((2 ** (bit_width - 1)) - 1);
   localparam logic signed [SW-1:0] C_MIN = SW'(-(2 ** (bit_width - 1)));

   logic [SIZE-1:0]                 r_idx;
   logic [SIZE-1:0]                 w_idx_use;

   logic                            r1_valid;
   logic                            r1_sop;
   logic signed [bit_width-1:0]     r1_re;
   logic signed [bit_width-1:0]     r1_im;

   logic                            r2_valid;
   logic                            r2_sop;
   logic signed [PW-1:0]            r2_rc;
   logic signed [PW-1:0]            r2_is;
   logic signed [PW-1:0]            r2_rs;
   logic signed [PW-1:0]            r2_ic;

   logic signed [PW-1:0]            w_re_x;
   logic signed [PW-1:0]            w_im_x;
   logic signed [PW-1:0]            w_cos_x;
   logic signed [PW-1:0]            w_sin_x;

   logic signed [SW-1:0]            w_re_sum;
   logic signed [SW-1:0]            w_im_sum;
   logic signed [SW-1:0]            w_re_sh;
   logic signed [SW-1:0]            w_im_sh;

   function automatic logic signed [bit_width-1:0] f_sat(
      input logic signed [SW-1:0] x
   );
      logic signed [SW-1:0] v;
      v = x;
      if (x > C_MAX) v = C_MAX;
      if (x < C_MIN) v = C_MIN;
      return v[bit_width-1:0];
   endfunction

   // sop restarts the index on the very sample that carries it
   assign w_idx_use    = (in_valid && in_sop) ? '0 : r_idx;
   assign rd_ptr_angle = w_idx_use[3] ? (SIZE-5)'(w_idx_use[2:0]) : '0;
   assign en           = in_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx <= '0;
      end else if (in_valid) begin
         r_idx <= (w_idx_use == SIZE'(N - 1)) ? '0 : w_idx_use + SIZE'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r1_valid <= 1'b0;
         r1_sop   <= 1'b0;
         r1_re    <= '0;
         r1_im    <= '0;
      end else begin
         r1_valid <= in_valid;
         r1_sop   <= in_valid & in_sop;
         if (in_valid) begin
            r1_re <= in_re;
            r1_im <= in_im;
         end
      end
   end

   assign w_re_x  = PW'(r1_re);
   assign w_im_x  = PW'(r1_im);
   assign w_cos_x = PW'(cos_data);
   assign w_sin_x = PW'(sin_data);

   always_ff @(posedge clk) begin
      if (rst) begin
         r2_valid <= 1'b0;
         r2_sop   <= 1'b0;
         r2_rc    <= '0;
         r2_is    <= '0;
         r2_rs    <= '0;
         r2_ic    <= '0;
      end else begin
         r2_valid <= r1_valid;
         r2_sop   <= r1_sop;
         if (r1_valid) begin
            r2_rc <= w_re_x * w_cos_x;
            r2_is <= w_im_x * w_sin_x;
            r2_rs <= w_re_x * w_sin_x;
            r2_ic <= w_im_x * w_cos_x;
         end
      end
   end

   // one extra bit keeps the sum of two full products overflow-free
   assign w_re_sum = SW'(r2_rc) - SW'(r2_is) + C_RND;
   assign w_im_sum = SW'(r2_rs) + SW'(r2_ic) + C_RND;
   assign w_re_sh  = w_re_sum >>> FRAC;
   assign w_im_sh  = w_im_sum >>> FRAC;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_sop   <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
      end else begin
         out_valid <= r2_valid;
         out_sop   <= r2_sop;
         if (r2_valid) begin
            out_re <= f_sat(w_re_sh);
            out_im <= f_sat(w_im_sh);
         end
      end
   end

endmodule

// File: tb/tb_stage5_twiddle_mult.sv
// Bench for stage5_twiddle_mult: vector table, reset/resync sequences and a
// randomly bubbled two-frame stream checked through a scoreboard queue.
module tb_stage5_twiddle_mult;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_sop;
   logic signed [15:0] in_re;
   logic signed [15:0] in_im;
   logic [2:0]         rd_ptr_angle;
   logic               en;
   logic signed [13:0] cos_data = '0;
   logic signed [13:0] sin_data = '0;
   logic               out_valid;
   logic               out_sop;
   logic signed [15:0] out_re;
   logic signed [15:0] out_im;

   always #5 clk = ~clk;

   stage5_twiddle_mult #(
      .N(256), .SIZE(8), .bit_width(16), .bit_width_tw(14)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_sop(in_sop),
      .in_re(in_re), .in_im(in_im),
      .rd_ptr_angle(rd_ptr_angle), .en(en),
      .cos_data(cos_data), .sin_data(sin_data),
      .out_valid(out_valid), .out_sop(out_sop),
      .out_re(out_re), .out_im(out_im)
   );

   typedef struct {
      logic signed [15:0] re;
      logic signed [15:0] im;
      logic               sop;
   } exp_t;

   typedef struct {
      int re;
      int im;
      int k;
      int xre;
      int xim;
   } vec_t;

   exp_t  sbq[$];
   vec_t  vt[16];
   int    checks = 0;
   int    errors = 0;
   int    m_idx  = 0;
   logic  [2:0] vh;
   logic signed [15:0] last_re;
   logic signed [15:0] last_im;

   function automatic int rom_c(int k);
      case (k)
         0: return 4096;   1: return 3784;
         2: return 2896;   3: return 1567;
         4: return 0;      5: return -1567;
         6: return -2896;  7: return -3784;
         default: return 0;
      endcase
   endfunction

   function automatic int rom_s(int k);
      case (k)
         0: return 0;      1: return -1567;
         2: return -2896;  3: return -3784;
         4: return -4096;  5: return -3784;
         6: return -2896;  7: return -1567;
         default: return 0;
      endcase
   endfunction

   function automatic logic signed [15:0] rnd_sat(longint a);
      longint v;
      v = (a + 2048) >>> 12;
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
      return 16'(v);
   endfunction

   // twiddle ROM: one-cycle read latency
   always @(posedge clk) begin
      if (en) begin
         cos_data <= 14'(rom_c(int'(rd_ptr_angle)));
         sin_data <= 14'(rom_s(int'(rd_ptr_angle)));
      end
   end

   always @(posedge clk) begin
      if (rst) vh <= '0;
      else     vh <= {vh[1:0], in_valid};
   end

   task automatic chk(input string n, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", n,
                  $signed(got), $signed(exp));
      end
   endtask

   task automatic send(input bit v, input bit s, input int re, input int im,
                       input bit use_x, input int xre, input int xim);
      int   u;
      int   k;
      exp_t e;
      @(posedge clk);
      #2;
      in_valid = v;
      in_sop   = s;
      in_re    = 16'(re);
      in_im    = 16'(im);
      #1;
      chk("en", 64'(en), 64'(v));
      if (v) begin
         u = s ? 0 : m_idx;
         k = ((u & 8) != 0) ? (u & 7) : 0;
         chk("rd_ptr_angle", 64'(rd_ptr_angle), 64'(k));
         m_idx = (u + 1) % 256;
         if (use_x) begin
            e.re = 16'(xre);
            e.im = 16'(xim);
         end else begin
            e.re = rnd_sat(longint'(re) * rom_c(k) - longint'(im) * rom_s(k));
            e.im = rnd_sat(longint'(re) * rom_s(k) + longint'(im) * rom_c(k));
         end
         e.sop = s;
         sbq.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         send(1'b0, 1'($urandom_range(0, 1)), int'($urandom), int'($urandom),
              1'b0, 0, 0);
   endtask

   initial begin
      int   nv;
      bit   v;
      exp_t e;

      for (int i = 0; i < 8; i++) vt[i] = '{1000, -500, 0, 1000, -500};
      vt[8]  = '{123, 456, 0, 123, 456};
      vt[9]  = '{1000, 0, 1, 924, -383};
      vt[10] = '{1000, 0, 2, 707, -707};
      vt[11] = '{0, 1000, 3, 924, 383};
      vt[12] = '{-32768, 0, 4, 0, 32767};
      vt[13] = '{-32768, -32768, 5, -17736, 32767};
      vt[14] = '{100, 100, 6, 0, -141};
      vt[15] = '{32767, 32767, 7, -17735, -32768};

      rst      = 1'b1;
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_re    = '0;
      in_im    = '0;
      last_re  = '0;
      last_im  = '0;

      fork
         forever begin
            @(negedge clk);
            if (rst) begin
               last_re = '0;
               last_im = '0;
            end else begin
               chk("out_valid_pattern", 64'(out_valid), 64'(vh[2]));
               if (out_valid === 1'b1) begin
                  if (sbq.size() == 0) begin
                     chk("unexpected_output", 64'(1), 64'(0));
                  end else begin
                     e = sbq.pop_front();
                     chk("out_re", 64'(out_re), 64'(e.re));
                     chk("out_im", 64'(out_im), 64'(e.im));
                     chk("out_sop", 64'(out_sop), 64'(e.sop));
                  end
                  last_re = out_re;
                  last_im = out_im;
               end else begin
                  chk("hold_re", 64'(out_re), 64'(last_re));
                  chk("hold_im", 64'(out_im), 64'(last_im));
               end
            end
         end
      join_none

      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_sop", 64'(out_sop), 64'(0));
      chk("rst_out_re", 64'(out_re), 64'(0));
      chk("rst_out_im", 64'(out_im), 64'(0));

      // vector table: one 16-sample block starting at sop
      for (int i = 0; i < 16; i++) begin
         send(1'b1, i == 0, vt[i].re, vt[i].im, 1'b1, vt[i].xre, vt[i].xim);
         chk("table_k", 64'(rd_ptr_angle), 64'(vt[i].k));
      end
      idle(4);

      // reset with samples in flight; idx would otherwise be 12
      send(1'b1, 1'b1, 11, 22, 1'b0, 0, 0);
      for (int i = 1; i < 12; i++)
         send(1'b1, 1'b0, i * 7, -i * 3, 1'b0, 0, 0);
      @(posedge clk);
      #2;
      rst      = 1'b1;
      in_valid = 1'b1;
      in_sop   = 1'b0;
      #1;
      chk("en_in_reset", 64'(en), 64'(1));
      @(posedge clk);
      #2;
      rst      = 1'b0;
      in_valid = 1'b0;
      sbq.delete();
      m_idx = 0;
      #1;
      chk("post_rst_valid", 64'(out_valid), 64'(0));
      chk("post_rst_re", 64'(out_re), 64'(0));
      chk("post_rst_im", 64'(out_im), 64'(0));
      send(1'b1, 1'b0, 500, 600, 1'b0, 0, 0);
      chk("post_rst_k0", 64'(rd_ptr_angle), 64'(0));
      for (int i = 1; i < 10; i++)
         send(1'b1, 1'b0, 300, -i, 1'b0, 0, 0);
      chk("post_rst_idx9", 64'(rd_ptr_angle), 64'(1));
      idle(4);

      // two bubbled frames: wrap without sop, then resync at idx 37
      nv = 0;
      while (nv < 512) begin
         v = ($urandom_range(0, 3) != 0);
         if (v) begin
            send(1'b1, (nv == 0) || (nv == 256 + 37),
                 int'($signed(16'($urandom))), int'($signed(16'($urandom))),
                 1'b0, 0, 0);
            nv++;
         end else begin
            idle(1);
         end
      end
      idle(4);

      for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
      chk("drain", 64'(sbq.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/stage5_twiddle_mult.md
STAGE5_TWIDDLE_MULT -- requirements
Module: stage5_twiddle_mult

Interface
REQ-001 SHALL have parameters: N, default 256, FFT length; SIZE, default 8, log2(N); bit_width, default 16, data width; bit_width_tw, default 14, twiddle width in Q1.12 (4096 = +1.0).
REQ-002 SHALL have port clk  input  1  single clock; all logic updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  input sample qualifier.
REQ-005 SHALL have port in_sop  input  1  first sample of a frame, meaningful only with in_valid.
REQ-006 SHALL have ports in_re, in_im  input  bit_width each  signed butterfly output of stage 4.
REQ-007 SHALL have port rd_ptr_angle  output  SIZE-5  twiddle ROM address, combinational from the sample index.
REQ-008 SHALL have port en  output  1  twiddle ROM read enable, equal to in_valid.
REQ-009 SHALL have ports cos_data, sin_data  input  bit_width_tw each  signed ROM data, valid one cycle after en.
REQ-010 SHALL have ports out_valid, out_sop  output  1 each  delayed in_valid and in_sop.
REQ-011 SHALL have ports out_re, out_im  output  bit_width each  signed twiddled result.

Function
REQ-012 SHALL keep a SIZE-bit sample index idx; an accepted sample (in_valid=1) uses idx=0 when in_sop=1, otherwise the current idx; idx then becomes used+1, wrapping from N-1 to 0.
REQ-013 SHALL hold idx when in_valid=0; in_sop with in_valid=0 SHALL be ignored.
REQ-014 SHALL drive rd_ptr_angle = idx[2:0] (sop-adjusted) when idx[3]=1, else 0, giving W16^k = 1 for the first 8 samples of each 16-sample block.
REQ-015 SHALL be a fixed 3-cycle pipeline with no backpressure: in_valid at cycle T gives out_valid at T+3; bubbles propagate unchanged.
REQ-016 Stage 1: SHALL register in_re, in_im, valid and sop alongside the ROM read.
REQ-017 Stage 2: SHALL register the four full-precision signed products re*cos, im*sin, re*sin and im*cos, each bit_width+bit_width_tw bits.
REQ-018 Stage 3: SHALL compute re' = re*cos - im*sin and im' = re*sin + im*cos at bit_width+bit_width_tw+1 bits without overflow.
REQ-019 Stage 3: SHALL add 2048, arithmetic-shift right by 12 (round half up), saturate to [-2^(bit_width-1), 2^(bit_width-1)-1], and register to out_re and out_im.
REQ-020 When W = 1 (cos=4096, sin=0), the output SHALL equal the input exactly.
REQ-021 out_re and out_im SHALL hold their last value while out_valid=0.
REQ-022 A sop with in_valid=1 arriving mid-frame SHALL restart idx at 0 for that sample, with no error flag.

Reset
REQ-023 While rst=1 at a clock edge: idx SHALL become 0; all pipeline valid and sop bits SHALL become 0; out_valid, out_sop, out_re and out_im SHALL become 0.
REQ-024 Reset asserted mid-frame SHALL discard all in-flight samples (no out_valid for them); the first accepted sample after reset SHALL use idx=0 even without in_sop.
REQ-025 en SHALL follow in_valid combinationally, including during reset; ROM data read during reset SHALL be discarded.

Verification
REQ-026 Identity: in_sop at idx 0, 8 samples (re=1000, im=-500), ROM returns 4096/0 -> out_re=1000, out_im=-500 exactly, out_valid 3 cycles after each in_valid, out_sop on the first output.
REQ-027 Twiddle k=1: sample at idx 9, re=1000, im=0, cos=3784, sin=-1567 -> rd_ptr_angle=1, out_re=924, out_im=-383.
REQ-028 Saturation: idx 12 (k=4, cos=0, sin=-4096), re=-32768, im=0 -> out_re=0, out_im=32767 (saturated from 32768).
REQ-029 Streaming with bubbles: random in_valid over 2 full frames (512 valid samples) -> rd_ptr_angle sequence 0,0,0,0,0,0,0,0,0,1,...,7 per 16 valid samples; outputs match the golden model bit-exactly; the out_valid pattern is in_valid delayed 3 cycles.
REQ-030 Wrap and re-sync: after 256 valid samples idx wraps to 0 without in_sop; an in_sop injected at idx 37 restarts idx at 0 on that sample.
REQ-031 Reset mid-operation: rst pulsed 1 cycle with 3 samples in flight -> no out_valid in the next 3 cycles; outputs = 0; the next sample uses rd_ptr_angle=0 and idx=0.
